// File: rtl/max3421_spi_seq.sv
// MAX3421 register access sequencer: frames a command byte plus one data byte
// with ss_n and hands each byte to an external byte-wide SPI master.
module max3421_spi_seq #(
  parameter int SETUP_CYC   = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_write,
  input  logic [4:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  input  logic       err_clr,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] status,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       ss_n,
  output logic       spi_start,
  output logic [7:0] spi_data_in,
  input  logic       spi_busy,
  input  logic       spi_new_data,
  input  logic [7:0] spi_data_out
);

  // state     | meaning
  // IDLE      | ss_n high, waiting for cmd_valid
  // SETUP     | ss_n low, settle time before the command byte
  // CMD_START | issue command byte once the SPI master is idle
  // CMD_WAIT  | wait for the status byte, timeout armed
  // DAT_START | issue data byte once the SPI master is idle
  // DAT_WAIT  | wait for the data byte, timeout armed
  // GAP       | ss_n high, enforced dead time before the next accept
  typedef enum logic [2:0] {
    IDLE, SETUP, CMD_START, CMD_WAIT, DAT_START, DAT_WAIT, GAP
  } state_t;

  localparam int MAX_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int MAX_CYC = (MAX_SG > TIMEOUT_CYC) ? MAX_SG : TIMEOUT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC);
  // Loaded on the spi_start cycle, so the last wait cycle is TIMEOUT_CYC-1 later.
  localparam logic [CW-1:0] TO_LD    = CW'(TIMEOUT_CYC - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [4:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            ss_n_q, ss_n_d;
  logic            done_q, done_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      status_q, status_d;
  logic [7:0]      sdi_q, sdi_d;
  logic            err_to_q, err_to_d;
  logic            err_ov_q, err_ov_d;
  logic            start_c;
  logic            to_set;
  logic            ov_set;
  logic [7:0]      cmd_byte;
  logic [7:0]      data_byte;

  assign cmd_byte  = {reg_q, 1'b0, wr_q, 1'b0};
  assign data_byte = wr_q ? wdata_q : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      reg_q    <= 5'd0;
      wdata_q  <= 8'h00;
      ss_n_q   <= 1'b1;
      done_q   <= 1'b0;
      rdata_q  <= 8'h00;
      status_q <= 8'h00;
      sdi_q    <= 8'h00;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      ss_n_q   <= ss_n_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      sdi_q    <= sdi_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    ss_n_d   = ss_n_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    status_d = status_q;
    sdi_d    = sdi_q;
    start_c  = 1'b0;
    to_set   = 1'b0;
    ov_set   = cmd_valid && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          reg_d   = cmd_reg;
          wdata_d = cmd_wdata;
          ss_n_d  = 1'b0;
          cnt_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q <= CNT_ONE) begin
          sdi_d   = cmd_byte;
          state_d = CMD_START;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CMD_START: begin
        if (!spi_busy) begin
          start_c = 1'b1;
          cnt_d   = TO_LD;
          state_d = CMD_WAIT;
        end
      end
      CMD_WAIT: begin
        if (spi_new_data) begin
          status_d = spi_data_out;
          sdi_d    = data_byte;
          state_d  = DAT_START;
        end else if (cnt_q <= CNT_ONE) begin
          to_set  = 1'b1;
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DAT_START: begin
        if (!spi_busy) begin
          start_c = 1'b1;
          cnt_d   = TO_LD;
          state_d = DAT_WAIT;
        end
      end
      DAT_WAIT: begin
        if (spi_new_data) begin
          if (!wr_q) begin
            rdata_d = spi_data_out;
          end
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else if (cnt_q <= CNT_ONE) begin
          to_set  = 1'b1;
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = GAP_LD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        ss_n_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A flag being raised wins over a simultaneous clear.
    err_to_d = (err_to_q & ~err_clr) | to_set;
    err_ov_d = (err_ov_q & ~err_clr) | ov_set;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign status      = status_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;
  assign ss_n        = ss_n_q;
  assign spi_start   = start_c;
  assign spi_data_in = sdi_q;

endmodule

// File: tb/tb_max3421_spi_seq.sv
// Bench for max3421_spi_seq: directed table of transactions plus randomized
// transactions, each run against a behavioural SPI master and checked.
module tb_max3421_spi_seq;
  localparam int SETUP_CYC   = 2;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_reg = 5'd0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       err_clr = 1'b0;
  logic       busy, done, err_timeout, err_overrun, ss_n, spi_start;
  logic [7:0] rdata, status, spi_data_in;
  logic       spi_busy = 1'b0;
  logic       spi_new_data = 1'b0;
  logic [7:0] spi_data_out = 8'h00;

  always #5 clk = ~clk;

  max3421_spi_seq #(
    .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .err_clr(err_clr), .busy(busy),
    .done(done), .rdata(rdata), .status(status), .err_timeout(err_timeout),
    .err_overrun(err_overrun), .ss_n(ss_n), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_busy(spi_busy), .spi_new_data(spi_new_data),
    .spi_data_out(spi_data_out)
  );

  typedef struct {
    logic       wr;
    logic [4:0] rg;
    logic [7:0] wd;
    logic [7:0] st_resp;
    logic [7:0] dt_resp;
    int         lat;
    int         hold;
    bit         noresp;
    bit         ovr;
    bit         stray;
    bit         rst_mid;
    logic [7:0] exp_cmd;
    logic [7:0] exp_dat;
    logic [7:0] exp_status;
    logic [7:0] exp_rdata;
    int         exp_starts;
    bit         exp_to;
    bit         exp_ov;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // Observations of one run.
  int         obs_starts, s1, s2, done_cnt, done_cyc, ssn_low, busy_fall;
  int         to_cyc, unstable, proto_bad, due;
  logic [7:0] obs_cmd, obs_dat, cur_byte;
  bit         pending, ovr_done, run_ok;

  // Reference-model state: what status/rdata should currently hold.
  logic [7:0] m_status = 8'h00;
  logic [7:0] m_rdata  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [4:0] rg, input logic [7:0] wd,
                              input logic [7:0] st, input logic [7:0] dt, input int lat,
                              input int hold, input bit noresp, input bit ovr, input bit stray,
                              input bit rstm, input logic [7:0] ec, input logic [7:0] ed,
                              input logic [7:0] es, input logic [7:0] er, input int est,
                              input bit eto, input bit eov);
    vec_t v;
    v.wr = wr; v.rg = rg; v.wd = wd; v.st_resp = st; v.dt_resp = dt;
    v.lat = lat; v.hold = hold; v.noresp = noresp; v.ovr = ovr; v.stray = stray;
    v.rst_mid = rstm; v.exp_cmd = ec; v.exp_dat = ed; v.exp_status = es;
    v.exp_rdata = er; v.exp_starts = est; v.exp_to = eto; v.exp_ov = eov;
    return v;
  endfunction

  // Expected results from the device rules, using plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_cmd    = 8'(int'(v.rg) * 8 + int'(v.wr) * 2);
    r.exp_dat    = v.wr ? v.wd : 8'h00;
    r.exp_status = v.noresp ? m_status : v.st_resp;
    r.exp_rdata  = (v.noresp || v.wr) ? m_rdata : v.dt_resp;
    r.exp_starts = v.noresp ? 1 : 2;
    r.exp_to     = v.noresp;
    r.exp_ov     = v.ovr && !v.noresp;
    return r;
  endfunction

  // Entered and left at posedge+1.
  task automatic run(input vec_t v);
    bit seen_busy;
    bit stop;
    int rst_done_seen;
    obs_starts = 0; s1 = -1; s2 = -1; done_cnt = 0; done_cyc = -1; ssn_low = 0;
    busy_fall = -1; to_cyc = -1; unstable = 0; proto_bad = 0; due = 0;
    obs_cmd = 8'h00; obs_dat = 8'h00; cur_byte = 8'h00; pending = 0; ovr_done = 0;
    seen_busy = 0; stop = 0;
    for (int cyc = 0; cyc < 400 && !stop; cyc++) begin
      cmd_valid = (cyc == 0);
      err_clr = 1'b0;
      if (cyc == 0) begin
        cmd_write = v.wr; cmd_reg = v.rg; cmd_wdata = v.wd;
      end else begin
        cmd_write = 1'($urandom); cmd_reg = 5'($urandom); cmd_wdata = 8'($urandom);
      end
      if (v.ovr && obs_starts == 2 && pending && !ovr_done) begin
        cmd_valid = 1'b1; cmd_write = ~v.wr; cmd_reg = ~v.rg; cmd_wdata = ~v.wd;
        err_clr = 1'b1; ovr_done = 1;
      end
      spi_busy = (cyc >= 1 && cyc <= v.hold) || pending;
      spi_new_data = pending && !v.noresp && cyc == due;
      spi_data_out = spi_new_data ? ((obs_starts == 1) ? v.st_resp : v.dt_resp) : 8'($urandom);
      if (v.stray && (cyc == 1 || (done_cyc >= 0 && cyc == done_cyc + 1))) begin
        spi_new_data = 1'b1; spi_data_out = 8'hEE;
      end
      #1;
      if (spi_start === 1'b1) begin
        obs_starts++;
        if (ss_n !== 1'b0 || spi_busy) proto_bad++;
        cur_byte = spi_data_in;
        if (obs_starts == 1) begin obs_cmd = spi_data_in; s1 = cyc; end
        else begin obs_dat = spi_data_in; s2 = cyc; end
        pending = 1; due = cyc + v.lat;
      end else if (pending && spi_data_in !== cur_byte) begin
        unstable++;
      end
      if (pending && !v.noresp && cyc == due) pending = 0;
      if (ss_n === 1'b0) ssn_low++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (err_timeout === 1'b1 && to_cyc < 0) to_cyc = cyc;
      if (busy === 1'b1) seen_busy = 1;
      else if (seen_busy && busy_fall < 0) busy_fall = cyc;
      if (busy_fall >= 0 && cyc >= busy_fall + 4) stop = 1;
      if (v.rst_mid && s2 >= 0 && cyc == s2 + 1) begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ss_n", ss_n, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_spi_start", spi_start, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_status", status, 8'h00);
        chk("rst_spi_data_in", spi_data_in, 8'h00);
        rst_done_seen = 0;
        repeat (3) begin
          @(posedge clk); #1;
          if (done !== 1'b0 || ss_n !== 1'b1) rst_done_seen++;
        end
        rst_n = 1'b1;
        stop = 1;
        chk("rst_no_done", rst_done_seen, 0);
      end
      @(posedge clk); #1;
    end
    run_ok = stop;
    cmd_valid = 1'b0; err_clr = 1'b0; spi_busy = 1'b0; spi_new_data = 1'b0; pending = 0;
  endtask

  task automatic check(input vec_t v);
    int exp_s1, exp_done;
    chk("run_budget", run_ok, 1'b1);
    if (v.rst_mid) begin
      m_status = 8'h00; m_rdata = 8'h00;
      return;
    end
    exp_s1   = (SETUP_CYC + 1 > v.hold + 1) ? SETUP_CYC + 1 : v.hold + 1;
    exp_done = v.noresp ? exp_s1 + TIMEOUT_CYC : exp_s1 + 2 * v.lat + 2;
    chk("starts", obs_starts, v.exp_starts);
    chk("cmd_byte", obs_cmd, v.exp_cmd);
    if (v.exp_starts == 2) chk("dat_byte", obs_dat, v.exp_dat);
    chk("status", status, v.exp_status);
    chk("rdata", rdata, v.exp_rdata);
    chk("done_cnt", done_cnt, 1);
    chk("err_timeout", err_timeout, v.exp_to);
    chk("err_overrun", err_overrun, v.exp_ov);
    chk("data_stable", unstable, 0);
    chk("start_protocol", proto_bad, 0);
    chk("first_start_cyc", s1, exp_s1);
    chk("done_cyc", done_cyc, exp_done);
    chk("ss_n_low_cycles", ssn_low, exp_done - 1);
    chk("gap_len", busy_fall - done_cyc, GAP_CYC);
    if (v.noresp) chk("timeout_cyc", to_cyc, exp_done);
    m_status = v.noresp ? m_status : v.st_resp;
    m_rdata  = (v.noresp || v.wr) ? m_rdata : v.dt_resp;
    if (err_timeout || err_overrun) begin
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      chk("err_clr_timeout", err_timeout, 1'b0);
      chk("err_clr_overrun", err_overrun, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    tbl[0] = mk(1, 5'd17, 8'hA5, 8'h3C, 8'h77, 3, 0,  0, 0, 0, 0, 8'h8A, 8'hA5, 8'h3C, 8'h00, 2, 0, 0);
    tbl[1] = mk(0, 5'd13, 8'hFF, 8'h10, 8'h5E, 2, 0,  0, 0, 0, 0, 8'h68, 8'h00, 8'h10, 8'h5E, 2, 0, 0);
    tbl[2] = mk(1, 5'd3,  8'h11, 8'h22, 8'h33, 4, 12, 0, 0, 0, 0, 8'h1A, 8'h11, 8'h22, 8'h5E, 2, 0, 0);
    tbl[3] = mk(0, 5'd31, 8'h00, 8'h44, 8'hC3, 5, 0,  0, 1, 0, 0, 8'hF8, 8'h00, 8'h44, 8'hC3, 2, 0, 1);
    tbl[4] = mk(1, 5'd9,  8'h5A, 8'h99, 8'h98, 1, 0,  1, 0, 0, 0, 8'h4A, 8'h5A, 8'h44, 8'hC3, 1, 1, 0);
    tbl[5] = mk(0, 5'd0,  8'h81, 8'h01, 8'h02, 1, 0,  0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 8'h02, 2, 0, 0);
    tbl[6] = mk(1, 5'd7,  8'h3D, 8'h55, 8'h66, 5, 0,  0, 0, 0, 1, 8'h3A, 8'h3D, 8'h55, 8'h02, 2, 0, 0);
    tbl[7] = mk(1, 5'd20, 8'h96, 8'h5A, 8'h00, 2, 0,  0, 0, 0, 0, 8'hA2, 8'h96, 8'h5A, 8'h00, 2, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ss_n", ss_n, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_spi_start", spi_start, 1'b0);
    chk("reset_rdata", rdata, 8'h00);
    chk("reset_status", status, 8'h00);
    chk("reset_errs", {err_timeout, err_overrun}, 2'b00);
    chk("reset_spi_data_in", spi_data_in, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run(tbl[i]);
      check(tbl[i]);
    end

    for (int i = 0; i < 30; i++) begin
      v = mk(1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(1, 6)), int'($urandom_range(0, 8)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0), 0,
             8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      v = model(v);
      run(v);
      check(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/max3421_spi_seq.md
MAX3421_SPI_SEQ -- requirements
Module: max3421_spi_seq

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2, clk cycles from ss_n low to first spi_start.
REQ-002 SHALL have parameter GAP_CYC, default 4, minimum clk cycles ss_n stays high between transactions.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, maximum clk cycles waiting for spi_new_data per byte.
REQ-004 SHALL have ports, one clock, reset asynchronous and active-low:
  clk  in  1  sole clock
  rst_n  in  1  asynchronous active-low reset
  cmd_valid  in  1  one-cycle request strobe
  cmd_write  in  1  1=register write, 0=register read
  cmd_reg  in  5  MAX3421 register number
  cmd_wdata  in  8  write data
  err_clr  in  1  clears sticky error flags
  busy  out  1  transaction in progress
  done  out  1  one-cycle completion pulse
  rdata  out  8  read data from last completed read
  status  out  8  status byte shifted back during command byte
  err_timeout  out  1  sticky, byte never completed
  err_overrun  out  1  sticky, cmd_valid while busy
  ss_n  out  1  MAX3421 slave select, active low
  spi_start  out  1  one-cycle start to SPI master
  spi_data_in  out  8  byte to SPI master
  spi_busy  in  1  SPI master busy
  spi_new_data  in  1  SPI master byte-complete pulse
  spi_data_out  in  8  byte received by SPI master

Function
REQ-005 SHALL implement states IDLE, SETUP, CMD_START, CMD_WAIT, DAT_START, DAT_WAIT, GAP.
REQ-006 IDLE: cmd_valid=1 SHALL latch cmd_write/cmd_reg/cmd_wdata, drive ss_n=0, set busy=1 next cycle, go to SETUP.
REQ-007 SETUP SHALL count SETUP_CYC cycles, then go to CMD_START.
REQ-008 Command byte SHALL be {cmd_reg[4:0], 1'b0, cmd_write, 1'b0}.
REQ-009 CMD_START/DAT_START SHALL pulse spi_start for exactly one cycle only when spi_busy=0; otherwise wait in state.
REQ-010 spi_data_in SHALL hold the byte stable from the spi_start cycle until spi_new_data.
REQ-011 CMD_WAIT: spi_new_data SHALL load status<=spi_data_out, go to DAT_START.
REQ-012 Data byte SHALL be cmd_wdata for writes, 8'h00 for reads.
REQ-013 DAT_WAIT: spi_new_data SHALL load rdata<=spi_data_out on reads only (rdata unchanged on writes), drive ss_n=1 next cycle, pulse done, go to GAP.
REQ-014 GAP SHALL hold ss_n=1, busy=1 for GAP_CYC cycles, then IDLE with busy=0.
REQ-015 CMD_WAIT/DAT_WAIT SHALL count cycles from spi_start; reaching TIMEOUT_CYC without spi_new_data SHALL set err_timeout, drive ss_n=1, pulse done, go to GAP; rdata/status unchanged by the aborted byte.
REQ-016 cmd_valid while busy=1 SHALL be ignored and set err_overrun; in-flight transaction unaffected.
REQ-017 err_clr=1 SHALL clear both error flags; simultaneous error set and err_clr SHALL leave flag set.
REQ-018 spi_new_data outside CMD_WAIT/DAT_WAIT SHALL be ignored.
REQ-019 busy SHALL be 1 from cycle after acceptance through last GAP cycle; back-to-back cmd_valid accepted first cycle busy=0.
REQ-020 Counters SHALL be wide enough for TIMEOUT_CYC without wrap.

Reset
REQ-021 rst_n=0 SHALL immediately force state IDLE, ss_n=1, spi_start=0, busy=0, done=0, rdata=0, status=0, err flags=0, spi_data_in=0, counters=0.
REQ-022 Reset mid-transaction SHALL abort with ss_n=1 and no done pulse.

Verification
REQ-023 Write: cmd_write=1, cmd_reg=5'd17, cmd_wdata=8'hA5, SPI model returns 8'h3C -> spi_data_in 8'h8A then 8'hA5, status=8'h3C, one done, rdata unchanged, ss_n low exactly across both bytes.
REQ-024 Read: cmd_write=0, cmd_reg=5'd13, model returns 8'h10 then 8'h5E -> command 8'h68, data 8'h00, status=8'h10, rdata=8'h5E.
REQ-025 Overrun: second cmd_valid during DAT_WAIT -> err_overrun=1, first transaction completes normally, no second transaction; err_clr clears flag.
REQ-026 Timeout: model never pulses spi_new_data, TIMEOUT_CYC=16 -> err_timeout=1 on cycle 16 after spi_start, ss_n=1, done pulse, busy=0 after GAP_CYC.
REQ-027 spi_busy held 1 for 10 cycles at CMD_START -> no spi_start until spi_busy=0; then single pulse.
REQ-028 rst_n=0 during DAT_WAIT -> ss_n=1, busy=0 same cycle, no done; next cmd_valid runs full transaction.
